// File: rtl/tristate_tx_pkg.sv
// Shared definitions for the tri-state serial transmitter: state encoding,
// parameter defaults and a counter-width helper.
package tristate_tx_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int BIT_DIV_DEF  = 4;
  localparam int TURN_CYC_DEF = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t LEAD  = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t TURN  = 2'd3;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tristate_tx_div.sv
// Bit-period divider: counts 0..BIT_DIV-1 while enabled and flags the last
// cycle of each bit period. Restart parks the count at zero.
module tristate_tx_div
  import tristate_tx_pkg::*;
#(
  parameter int BIT_DIV = BIT_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_end
);

  localparam int CNT_W = cnt_w(BIT_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(BIT_DIV - 1));
  assign o_end  = i_enable && w_last;

  // Period counter with wrap at BIT_DIV-1.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tristate_tx_seq.sv
// Tri-state serial transmitter: start bit, DATA_W data bits MSB first, then a
// released turnaround before the next idle acceptance. Back-to-back words keep
// the pad driven. Pad, busy and done outputs are registered.
module tristate_tx_seq
  import tristate_tx_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BIT_DIV  = BIT_DIV_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  input  logic              i_abort,
  output logic              o_pad_i,
  output logic              o_pad_t,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int TURN_W = cnt_w(TURN_CYC);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_cnt_nxt;
  logic              w_pad_i_nxt, w_pad_t_nxt, w_busy_nxt, w_done_nxt;
  logic              w_driving, w_abort, w_bit_end, w_last_bit, w_word_end;
  logic              w_accept;

  assign w_driving  = (r_state == LEAD) || (r_state == SHIFT);
  assign w_abort    = i_abort && w_driving;
  assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_W - 1));
  // Final cycle of the last data bit, unless an abort claims it.
  assign w_word_end = (r_state == SHIFT) && w_bit_end && w_last_bit && !i_abort;
  assign o_tx_ready = (r_state == IDLE) || w_word_end;
  assign w_accept   = i_tx_valid && o_tx_ready;

  tristate_tx_div #(
    .BIT_DIV (BIT_DIV)
  ) u_div (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_enable  (w_driving),
    .i_restart (!w_driving || i_abort),
    .o_end     (w_bit_end)
  );

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_turn_cnt <= '0;
      o_pad_i    <= 1'b1;
      o_pad_t    <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      o_pad_i    <= w_pad_i_nxt;
      o_pad_t    <= w_pad_t_nxt;
      o_busy     <= w_busy_nxt;
      o_done     <= w_done_nxt;
    end
  end

  // Next-state decode; abort in LEAD/SHIFT wins over everything else.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned
    // and a latch is never inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = LEAD;
      LEAD: begin
        if (i_abort)        w_state_nxt = TURN;
        else if (w_bit_end) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (i_abort)         w_state_nxt = TURN;
        else if (w_word_end) w_state_nxt = w_accept ? LEAD : TURN;
      end
      TURN:    if (r_turn_cnt == TURN_W'(TURN_CYC - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath next values: word latch, shift, bit and turnaround counters.
  always_comb begin
    w_data_nxt     = r_data;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_turn_cnt_nxt = '0;
    if (w_accept) begin
      w_data_nxt    = i_tx_data;
      w_bit_cnt_nxt = '0;
    end else if (w_abort) begin
      w_data_nxt    = '0;
      w_bit_cnt_nxt = '0;
    end else if ((r_state == SHIFT) && w_bit_end) begin
      w_data_nxt    = r_data << 1;
      w_bit_cnt_nxt = w_last_bit ? '0 : r_bit_cnt + 1'b1;
    end
    if ((r_state == TURN) && (w_state_nxt == TURN)) begin
      w_turn_cnt_nxt = r_turn_cnt + 1'b1;
    end
  end

  // Output decode from the upcoming state so outputs align with it.
  always_comb begin
    w_pad_i_nxt = 1'b1;
    w_pad_t_nxt = 1'b1;
    w_busy_nxt  = (w_state_nxt != IDLE);
    w_done_nxt  = w_word_end;
    case (w_state_nxt)
      LEAD: begin
        w_pad_i_nxt = 1'b0;
        w_pad_t_nxt = 1'b0;
      end
      SHIFT: begin
        w_pad_i_nxt = w_data_nxt[DATA_W-1];
        w_pad_t_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tristate_tx_seq.sv
// Bench for tristate_tx_seq: a default instance (8 bits, 4 cycles/bit, 2 turn
// cycles) and a wide instance (32 bits, 1 cycle/bit, 3 turn cycles). Expected
// pad waveforms come from frame arithmetic on the word and cycle offset.
module tb_tristate_tx_seq;

  localparam int DW = 8, BD = 4, TC = 2;
  localparam int FRAME = BD * (DW + 1);
  localparam int DW2 = 32, BD2 = 1, TC2 = 3;
  localparam int FRAME2 = BD2 * (DW2 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] data;
  logic          valid, ready, abort, pad_i, pad_t, busy, done;

  logic [DW2-1:0] data2;
  logic           valid2, ready2, abort2, pad_i2, pad_t2, busy2, done2;

  int checks = 0;
  int errors = 0;

  tristate_tx_seq #(.DATA_W(DW), .BIT_DIV(BD), .TURN_CYC(TC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(data), .i_tx_valid(valid),
    .o_tx_ready(ready), .i_abort(abort), .o_pad_i(pad_i), .o_pad_t(pad_t),
    .o_busy(busy), .o_done(done)
  );

  tristate_tx_seq #(.DATA_W(DW2), .BIT_DIV(BD2), .TURN_CYC(TC2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(data2), .i_tx_valid(valid2),
    .o_tx_ready(ready2), .i_abort(abort2), .o_pad_i(pad_i2), .o_pad_t(pad_t2),
    .o_busy(busy2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pad level at offset k (1-based) after acceptance: start bit, then bits MSB first.
  function automatic logic exp_pad_i(input logic [31:0] w, input int dw, input int bd, input int k);
    if (k <= bd) return 1'b0;
    return w[dw - 1 - (k - bd - 1) / bd];
  endfunction

  task automatic accept(input logic [DW-1:0] w);
    data  = w;
    valid = 1'b1;
    abort = 1'b0;
    #1;
    check("ready_at_accept", ready, 1);
    tick;
  endtask

  // Checks cycles 1..FRAME of a word; optionally aborts at offset abort_k,
  // chains w_next at the last cycle, or scrambles data with valid held high.
  task automatic body(input logic [DW-1:0] w, input int abort_k, input bit chain,
                      input logic [DW-1:0] w_next, input bit noise, input bit first_done);
    for (int k = 1; k <= FRAME; k++) begin
      check("pad_t_drive", pad_t, 0);
      check("pad_i_bit", pad_i, exp_pad_i(w, DW, BD, k));
      check("busy_drive", busy, 1);
      check("done_drive", done, (k == 1) && first_done);
      abort = (k == abort_k);
      valid = (k == FRAME) ? chain : noise;
      data  = (k == FRAME && chain) ? w_next : DW'($urandom);
      #1;
      check("ready_drive", ready, (k == FRAME) && (k != abort_k));
      tick;
      if (k == abort_k) begin
        abort = 1'b0;
        valid = 1'b0;
        return;
      end
    end
    abort = 1'b0;
    if (!chain) valid = 1'b0;
  endtask

  // TURN phase (valid held high to confirm refusal) followed by one IDLE cycle.
  task automatic turn_tail(input bit exp_done, input bit abort_in_turn);
    for (int c = 0; c < TC; c++) begin
      check("pad_t_turn", pad_t, 1);
      check("pad_i_turn", pad_i, 1);
      check("busy_turn", busy, 1);
      check("done_turn", done, (c == 0) && exp_done);
      abort = abort_in_turn;
      valid = 1'b1;
      #1;
      check("ready_turn", ready, 0);
      tick;
    end
    abort = 1'b0;
    valid = 1'b0;
    check("busy_idle", busy, 0);
    check("pad_t_idle", pad_t, 1);
    check("pad_i_idle", pad_i, 1);
    check("done_idle", done, 0);
    check("ready_idle", ready, 1);
  endtask

  // Full frame on the wide instance.
  task automatic frame2(input logic [DW2-1:0] w);
    data2  = w;
    valid2 = 1'b1;
    #1;
    check("w_ready_accept", ready2, 1);
    tick;
    for (int k = 1; k <= FRAME2; k++) begin
      valid2 = 1'b0;
      data2  = $urandom;
      check("w_pad_t", pad_t2, 0);
      check("w_pad_i", pad_i2, exp_pad_i(w, DW2, BD2, k));
      check("w_done_drive", done2, 0);
      tick;
    end
    for (int c = 0; c < TC2; c++) begin
      check("w_pad_t_turn", pad_t2, 1);
      check("w_done", done2, c == 0);
      check("w_ready_turn", ready2, 0);
      tick;
    end
    check("w_ready_idle", ready2, 1);
    check("w_busy_idle", busy2, 0);
  endtask

  initial begin
    logic [DW-1:0] w [0:4];
    rst_n  = 1'b0;
    valid  = 1'b0;
    abort  = 1'b0;
    data   = '0;
    valid2 = 1'b0;
    abort2 = 1'b0;
    data2  = '0;
    repeat (3) tick;
    check("rst_pad_t", pad_t, 1);
    check("rst_pad_i", pad_i, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    check("rst_w_pad_t", pad_t2, 1);
    rst_n = 1'b1;
    tick;

    // Abort while idle has no effect.
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_pad_t", pad_t, 1);

    // Single word 0xA5.
    accept(8'hA5);
    body(8'hA5, 0, 1'b0, '0, 1'b0, 1'b0);
    turn_tail(1'b1, 1'b0);

    // Back-to-back 0xFF then 0x00.
    accept(8'hFF);
    body(8'hFF, 0, 1'b1, 8'h00, 1'b0, 1'b0);
    body(8'h00, 0, 1'b0, '0, 1'b0, 1'b1);
    turn_tail(1'b1, 1'b0);

    // Abort at offset 10.
    accept(8'hA5);
    body(8'hA5, 10, 1'b0, '0, 1'b0, 1'b0);
    turn_tail(1'b0, 1'b0);

    // Abort coinciding with a chained accept at the last bit.
    accept(8'h3C);
    body(8'h3C, FRAME, 1'b1, 8'hC3, 1'b0, 1'b0);
    turn_tail(1'b0, 1'b0);

    // Abort during TURN is ignored.
    accept(8'h5A);
    body(8'h5A, 0, 1'b0, '0, 1'b0, 1'b0);
    turn_tail(1'b1, 1'b1);

    // Random chained words with scrambled data while valid is held.
    for (int i = 0; i < 5; i++) w[i] = DW'($urandom);
    accept(w[0]);
    for (int i = 0; i < 5; i++) begin
      body(w[i], 0, i < 4, (i < 4) ? w[(i + 1) % 5] : '0, 1'b1, i > 0);
    end
    turn_tail(1'b1, 1'b0);

    // Random abort point inside a random word.
    w[0] = DW'($urandom);
    accept(w[0]);
    body(w[0], $urandom_range(FRAME - 1, 1), 1'b0, '0, 1'b1, 1'b0);
    turn_tail(1'b0, 1'b0);

    // Reset asserted at offset 20 mid-word.
    accept(8'hA5);
    valid = 1'b0;
    repeat (19) tick;
    rst_n = 1'b0;
    tick;
    check("mid_rst_pad_t", pad_t, 1);
    check("mid_rst_pad_i", pad_i, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", ready, 1);
    for (int c = 0; c < FRAME; c++) begin
      tick;
      check("post_rst_done", done, 0);
      check("post_rst_pad_t", pad_t, 1);
    end

    // Wide instance: 32-bit words at one cycle per bit.
    frame2(32'h8000_0001);
    frame2($urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tristate_tx_seq.md
TRISTATE_TX_SEQ -- requirements
Module: tristate_tx_seq

Interface
REQ-001 Parameter DATA_W, default 8: width of each transmitted word; legal range 2..32.
REQ-002 Parameter BIT_DIV, default 4: CLK cycles per bit period; legal range 1..256.
REQ-003 Parameter TURN_CYC, default 2: released (T=1) cycles after a burst before new acceptance; legal range 1..64.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST_N  input  1  reset, synchronous, active-low.
REQ-006 TX_DATA  input  DATA_W  word to transmit, MSB first.
REQ-007 TX_VALID  input  1  TX_DATA valid.
REQ-008 TX_READY  output  1  word accepted on cycle where TX_VALID&TX_READY.
REQ-009 ABORT  input  1  terminate current transmission.
REQ-010 PAD_I  output  1  data to tri-state output buffer I pin.
REQ-011 PAD_T  output  1  enable to tri-state buffer T pin (0 = drive, 1 = high-Z).
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 DONE  output  1  one-cycle pulse per fully transmitted word.

Function
REQ-014 The FSM shall have states IDLE, LEAD, SHIFT and TURN.
REQ-015 PAD_I, PAD_T, BUSY and DONE shall be registered outputs; TX_READY is combinational from state and counters.
REQ-016 IDLE: PAD_T=1, PAD_I=1, TX_READY=1; on accept at cycle n, latch TX_DATA, enter LEAD, with PAD_T=0, PAD_I=0 from cycle n+1.
REQ-017 LEAD: drive PAD_I=0 (start bit) for exactly BIT_DIV cycles, then enter SHIFT.
REQ-018 SHIFT: drive DATA_W bits MSB first, each held exactly BIT_DIV cycles, PAD_T=0 throughout.
REQ-019 TX_READY shall be high in the final cycle of the last SHIFT bit; an accept there latches the next word and enters LEAD with PAD_T held 0 (no release gap).
REQ-020 DONE shall pulse for one cycle, on the cycle after the final cycle of the last bit.
REQ-021 With no accept at the end of the last bit, the block shall enter TURN: PAD_T=1, PAD_I=1, TX_READY=0, for exactly TURN_CYC cycles, then IDLE.
REQ-022 ABORT sampled high in LEAD or SHIFT shall force TURN on the next cycle, with no DONE and the latched word discarded.
REQ-023 ABORT shall take priority over a simultaneous accept at the end of the last bit; that word is not accepted (TX_READY forced 0).
REQ-024 ABORT in IDLE or TURN shall have no effect.
REQ-025 TX_DATA changes while not accepted shall not affect the word in transmission.
REQ-026 The bit-period counter shall count 0..BIT_DIV-1 and wrap; the bit counter shall be sized $clog2(DATA_W+1) bits, with no overflow at DATA_W=32.

Reset
REQ-027 While RST_N=0 at a rising edge: state=IDLE, PAD_T=1, PAD_I=1, BUSY=0, DONE=0, counters=0, data register=0.
REQ-028 Reset mid-transmission shall release the pad (PAD_T=1) on the next edge, with no DONE and no TURN phase.

Structure
REQ-029 Package tristate_tx_pkg shall hold the state encoding localparams (IDLE=0, LEAD=1, SHIFT=2, TURN=3) and the parameter defaults.
REQ-030 The bit-period divider shall be a sub-module tristate_tx_div (inputs: enable, restart; output: end-of-period strobe).

Verification (DATA_W=8, BIT_DIV=4, TURN_CYC=2)
REQ-031 Single word 0xA5 accepted at cycle 0 -> PAD_T=0 cycles 1..36; PAD_I=0 cycles 1..4, then bits 1,0,1,0,0,1,0,1 in 4-cycle groups; DONE at cycle 37; PAD_T=1 and TX_READY=0 cycles 37..38; TX_READY=1 from cycle 39.
REQ-032 Back-to-back 0xFF then 0x00, second accepted at cycle 36 -> PAD_T stays 0 cycles 1..72, DONE at 37 and 73, PAD_I=0 cycles 37..72.
REQ-033 ABORT at cycle 10 during 0xA5 -> PAD_T=1 from cycle 11, no DONE, TX_READY=1 at cycle 13.
REQ-034 RST_N=0 at cycle 20 mid-word -> PAD_T=1, PAD_I=1, BUSY=0 at cycle 21, TX_READY=1.
REQ-035 TX_VALID held with TX_DATA changing every cycle during SHIFT -> transmitted bits equal the word latched at accept only.
REQ-036 BIT_DIV=1, DATA_W=32, word 0x80000001 -> 33 driven cycles, correct bit order, DONE once.
